// File: rtl/memory_write_control.sv
// Input-side frame writer: decimates a DE-qualified video stream 2:1 in both directions
// and writes the kept pixels densely into frame memory, flagging frame completion and overflow.
module memory_write_control #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_DEPTH = 512 * 512 / 4,
  parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [10:0]           i_hres,
  input  logic [10:0]           i_vres,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_frame_done,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(ADDR_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e state_q, state_d;

  logic                  vsync_q, de_q;
  logic                  vs_rise, de_fall, last_row, qual, active;
  logic [11:0]           col_cnt_q, col_cnt_d;
  logic [11:0]           row_cnt_q, row_cnt_d;
  logic [11:0]           row_inc;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  full_q, full_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;

  // Line sync carries no information the DE stream does not already give.
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  assign vs_rise  = i_vsync & ~vsync_q;
  assign de_fall  = ~i_de & de_q;
  assign active   = (state_q == StActive);
  assign row_inc  = row_cnt_q + 12'd1;
  assign last_row = (row_inc == {1'b0, i_vres});
  assign qual     = active & i_de & (col_cnt_q < {1'b0, i_hres}) &
                    ~col_cnt_q[0] & ~row_cnt_q[0];

  // State register
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new frame sync wins over everything else
  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = StActive;
    end else if (active && de_fall && last_row) begin
      state_d = StDone;
    end
  end

  // Counter and write-port next values
  always_comb begin
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    addr_d       = addr_q;
    full_d       = full_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (vs_rise) begin
      col_cnt_d  = '0;
      row_cnt_d  = '0;
      addr_d     = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
    end else if (active) begin
      if (de_fall) begin
        col_cnt_d    = '0;
        row_cnt_d    = row_inc;
        frame_done_d = last_row;
      end else if (i_de && (col_cnt_q != 12'hfff)) begin
        col_cnt_d = col_cnt_q + 12'd1;
      end
      if (qual) begin
        if (!full_q) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = i_data;
          // The address sticks at the last word once the memory is full.
          if (addr_q == AddrLast) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Sync/DE history resets high so levels already present at release are not edges.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b1;
      de_q         <= 1'b1;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      addr_q       <= '0;
      full_q       <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      vsync_q      <= i_vsync;
      de_q         <= i_de;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      addr_q       <= addr_d;
      full_q       <= full_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_wen        = wen_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_memory_write_control.sv
// Directed bench for memory_write_control: frame vectors from a table plus hand-written
// sequences for idle/done gating, frame abort and mid-frame reset.
module tb_memory_write_control;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          i_clk = 1'b0;
  logic          rst;
  logic          i_vsync, i_hsync, i_de;
  logic [DW-1:0] i_data;
  logic [10:0]   i_hres, i_vres;
  logic          o_wen;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_frame_done;
  logic          o_overflow;

  always #5 i_clk = ~i_clk;

  memory_write_control #(
    .DATA_WIDTH(DW),
    .ADDR_DEPTH(DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .rst         (rst),
    .i_vsync     (i_vsync),
    .i_hsync     (i_hsync),
    .i_de        (i_de),
    .i_data      (i_data),
    .i_hres      (i_hres),
    .i_vres      (i_vres),
    .o_wen       (o_wen),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_frame_done(o_frame_done),
    .o_overflow  (o_overflow)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int hres;
    int vres;
    int de_len;
    int exp_writes;
    int exp_ovf;
    int exp_done;
  } frame_vec_t;

  int  checks   = 0;
  int  failures = 0;
  wr_t wq[$];
  wr_t eq[$];
  int  done_cnt, done_step, ovf_at, step_no, fall_step;
  bit  ovf_seen;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_obs();
    wq.delete();
    done_cnt  = 0;
    done_step = -1;
    ovf_seen  = 1'b0;
    ovf_at    = -1;
  endtask

  // Drive one cycle of inputs, then observe the registered outputs just after the edge.
  task automatic step(input bit vs, input bit de, input int d);
    wr_t w;
    i_vsync = vs;
    i_de    = de;
    i_hsync = ~de;
    i_data  = DW'(d);
    @(posedge i_clk);
    #1;
    step_no++;
    if (o_wen === 1'b1) begin
      check("wdata_latency", int'(o_wdata), d);
      w.addr = int'(o_waddr);
      w.data = int'(o_wdata);
      wq.push_back(w);
    end
    if (o_frame_done === 1'b1) begin
      done_cnt++;
      done_step = step_no;
    end
    if (o_overflow === 1'b1 && !ovf_seen) begin
      ovf_seen = 1'b1;
      ovf_at   = wq.size();
    end
  endtask

  // Reference write list for a frame of vres lines of de_len DE cycles each.
  function automatic void build_exp(input int hres, input int vres, input int de_len);
    wr_t w;
    int  a;
    eq.delete();
    a = 0;
    for (int r = 0; r < vres; r++) begin
      for (int c = 0; c < de_len; c++) begin
        if ((r % 2 == 0) && (c % 2 == 0) && (c < hres) && (a < int'(DEPTH))) begin
          w.addr = a;
          w.data = r * 16 + c;
          eq.push_back(w);
          a++;
        end
      end
    end
  endfunction

  task automatic run_frame(input int hres, input int vres, input int de_len);
    i_hres = 11'(hres);
    i_vres = 11'(vres);
    step(0, 0, 0);
    clear_obs();
    step(1, 0, 0);
    check("ovf_cleared_by_vsync", int'(o_overflow), 0);
    step(0, 0, 0);
    for (int r = 0; r < vres; r++) begin
      for (int c = 0; c < de_len; c++) step(0, 1, r * 16 + c);
      step(0, 0, 0);
      fall_step = step_no;
      step(0, 0, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic check_writes(input string name);
    check({name, "_count"}, wq.size(), eq.size());
    for (int k = 0; k < eq.size(); k++) begin
      if (k < wq.size()) begin
        check({name, "_addr"}, wq[k].addr, eq[k].addr);
        check({name, "_data"}, wq[k].data, eq[k].data);
      end
    end
  endtask

  frame_vec_t vecs[6];
  int         t1_data[8];

  initial begin
    vecs[0] = '{hres: 8,  vres: 4, de_len: 8,  exp_writes: 8,  exp_ovf: 0, exp_done: 1};
    vecs[1] = '{hres: 5,  vres: 3, de_len: 7,  exp_writes: 6,  exp_ovf: 0, exp_done: 1};
    vecs[2] = '{hres: 10, vres: 8, de_len: 10, exp_writes: 16, exp_ovf: 1, exp_done: 1};
    vecs[3] = '{hres: 1,  vres: 1, de_len: 3,  exp_writes: 1,  exp_ovf: 0, exp_done: 1};
    vecs[4] = '{hres: 4,  vres: 2, de_len: 2,  exp_writes: 1,  exp_ovf: 0, exp_done: 1};
    vecs[5] = '{hres: 6,  vres: 5, de_len: 6,  exp_writes: 9,  exp_ovf: 0, exp_done: 1};
    t1_data = '{'h00, 'h02, 'h04, 'h06, 'h20, 'h22, 'h24, 'h26};

    step_no = 0;
    clear_obs();
    rst     = 1'b1;
    i_vsync = 1'b0;
    i_hsync = 1'b1;
    i_de    = 1'b0;
    i_data  = '0;
    i_hres  = 11'd8;
    i_vres  = 11'd4;
    #12;
    check("rst_wen", int'(o_wen), 0);
    check("rst_waddr", int'(o_waddr), 0);
    check("rst_wdata", int'(o_wdata), 0);
    check("rst_done", int'(o_frame_done), 0);
    check("rst_ovf", int'(o_overflow), 0);
    @(posedge i_clk);
    #1;
    rst = 1'b0;

    // DE activity before any frame sync must not write.
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 'h100 + k);
      step(0, k % 2, 'h200 + k);
    end
    step(0, 0, 0);
    check("idle_no_writes", wq.size(), 0);
    check("idle_no_done", done_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].hres, vecs[i].vres, vecs[i].de_len);
      build_exp(vecs[i].hres, vecs[i].vres, vecs[i].de_len);
      check("vec_writes", wq.size(), vecs[i].exp_writes);
      check_writes("vec");
      check("vec_done_count", done_cnt, vecs[i].exp_done);
      check("vec_done_timing", done_step, fall_step);
      check("vec_overflow", int'(o_overflow), vecs[i].exp_ovf);
      if (vecs[i].exp_ovf != 0) check("ovf_first_drop", ovf_at, int'(DEPTH));
      if (i == 0) begin
        for (int k = 0; k < 8; k++) begin
          check("t1_data", (k < wq.size()) ? wq[k].data : -1, t1_data[k]);
        end
      end
    end

    // After frame completion DE is ignored until the next sync.
    clear_obs();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 6; c++) step(0, 1, 'h300 + c);
      step(0, 0, 0);
    end
    check("done_gate_no_writes", wq.size(), 0);
    check("done_gate_no_done", done_cnt, 0);

    // Frame abort: sync rise on a qualified pixel of line 2.
    i_hres = 11'd8;
    i_vres = 11'd4;
    step(0, 0, 0);
    clear_obs();
    step(1, 0, 0);
    step(0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) step(0, 1, r * 16 + c);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    for (int c = 0; c < 4; c++) step(0, 1, 'h20 + c);
    step(1, 1, 'h24);
    step(0, 1, 'h25);
    step(0, 1, 'h26);
    step(0, 1, 'h27);
    step(0, 0, 0);
    step(0, 0, 0);
    eq.delete();
    eq.push_back('{addr: 0, data: 'h00});
    eq.push_back('{addr: 1, data: 'h02});
    eq.push_back('{addr: 2, data: 'h04});
    eq.push_back('{addr: 3, data: 'h06});
    eq.push_back('{addr: 4, data: 'h20});
    eq.push_back('{addr: 5, data: 'h22});
    eq.push_back('{addr: 0, data: 'h25});
    eq.push_back('{addr: 1, data: 'h27});
    check_writes("abort");
    check("abort_no_done", done_cnt, 0);

    // Reset while a write is on the port, with vsync held high across release.
    step(0, 0, 0);
    clear_obs();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 'h40);
    check("pre_rst_wen", int'(o_wen), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wen", int'(o_wen), 0);
    check("async_rst_waddr", int'(o_waddr), 0);
    check("async_rst_wdata", int'(o_wdata), 0);
    check("async_rst_done", int'(o_frame_done), 0);
    check("async_rst_ovf", int'(o_overflow), 0);
    @(posedge i_clk);
    #1;
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < 6; c++) step(1, 1, 'h50 + c);
    step(1, 0, 0);
    check("post_rst_no_writes", wq.size(), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 'h55);
    step(1, 1, 'h56);
    step(1, 1, 'h57);
    step(1, 0, 0);
    eq.delete();
    eq.push_back('{addr: 0, data: 'h55});
    eq.push_back('{addr: 1, data: 'h57});
    check_writes("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
